// File: rtl/dance_pkg.sv
// Shared encodings for the dance-game datapath: arrow and grade codes,
// playfield geometry and the scroll scheduler state encoding.
package dance_pkg;

    localparam int SLOTS   = 26;
    localparam int ARROW_W = 3;
    localparam int GRADE_W = 2;
    localparam int ARRAY_W = SLOTS * ARROW_W;

    localparam logic [ARROW_W-1:0] ARROW_NONE  = 3'b000;
    localparam logic [ARROW_W-1:0] ARROW_UP    = 3'b001;
    localparam logic [ARROW_W-1:0] ARROW_LEFT  = 3'b010;
    localparam logic [ARROW_W-1:0] ARROW_DOWN  = 3'b011;
    localparam logic [ARROW_W-1:0] ARROW_RIGHT = 3'b100;
    localparam logic [ARROW_W-1:0] ARROW_SHAKE = 3'b110;

    localparam logic [GRADE_W-1:0] GRADE_NONE      = 2'b00;
    localparam logic [GRADE_W-1:0] GRADE_BAD       = 2'b01;
    localparam logic [GRADE_W-1:0] GRADE_GOOD      = 2'b10;
    localparam logic [GRADE_W-1:0] GRADE_EXCELLENT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/player_lane_state.sv
// Per-player lane: single-entry pending arrow, 26-slot scroll array and the
// hit-grade indicator with its shadow register and hold counter.
module player_lane_state
    import dance_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               run,
    input  logic               clear,
    input  logic               step,
    input  logic               vsync_pulse,
    input  logic [ARROW_W-1:0] new_arrow,
    input  logic               new_valid,
    output logic               new_ready,
    input  logic [GRADE_W-1:0] hit_grade,
    input  logic               hit_valid,
    output logic [ARRAY_W-1:0] arrow_array,
    output logic [GRADE_W-1:0] indicator,
    output logic               drained
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

    logic               pend_valid_q, pend_valid_d;
    logic [ARROW_W-1:0] pend_arrow_q, pend_arrow_d;
    logic [ARRAY_W-1:0] arr_q, arr_d;
    logic               shadow_valid_q, shadow_valid_d;
    logic [GRADE_W-1:0] shadow_grade_q, shadow_grade_d;
    logic [7:0]         hold_q, hold_d;
    logic [GRADE_W-1:0] ind_q, ind_d;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        new_ready      = run & ~clear & ~pend_valid_q;
        pend_valid_d   = pend_valid_q;
        pend_arrow_d   = pend_arrow_q;
        arr_d          = arr_q;
        shadow_valid_d = shadow_valid_q;
        shadow_grade_d = shadow_grade_q;
        hold_d         = hold_q;
        ind_d          = ind_q;

        // Capture only happens with pending empty, so a same-cycle step never inserts it.
        if (clear || !run) begin
            pend_valid_d = 1'b0;
            pend_arrow_d = ARROW_NONE;
        end else if (new_valid && new_ready) begin
            pend_valid_d = 1'b1;
            pend_arrow_d = new_arrow;
        end else if (step) begin
            pend_valid_d = 1'b0;
            pend_arrow_d = ARROW_NONE;
        end

        if (clear) begin
            arr_d = '0;
        end else if (step) begin
            arr_d = {arr_q[ARRAY_W-ARROW_W-1:0], (run && pend_valid_q) ? pend_arrow_q : ARROW_NONE};
        end

        if (clear) begin
            shadow_valid_d = 1'b0;
            shadow_grade_d = GRADE_NONE;
            hold_d         = '0;
            ind_d          = GRADE_NONE;
        end else begin
            if (vsync_pulse) begin
                if (shadow_valid_q) begin
                    ind_d          = shadow_grade_q;
                    hold_d         = HOLD_INIT;
                    shadow_valid_d = 1'b0;
                end else if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q == 8'd1) ind_d = GRADE_NONE;
                end
            end
            // A strobe coinciding with vsync lands in the shadow for the next frame.
            if (hit_valid) begin
                shadow_valid_d = 1'b1;
                shadow_grade_d = hit_grade;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_valid_q   <= 1'b0;
            pend_arrow_q   <= ARROW_NONE;
            arr_q          <= '0;
            shadow_valid_q <= 1'b0;
            shadow_grade_q <= GRADE_NONE;
            hold_q         <= '0;
            ind_q          <= GRADE_NONE;
        end else begin
            pend_valid_q   <= pend_valid_d;
            pend_arrow_q   <= pend_arrow_d;
            arr_q          <= arr_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_grade_q <= shadow_grade_d;
            hold_q         <= hold_d;
            ind_q          <= ind_d;
        end
    end

    assign arrow_array = arr_q;
    assign indicator   = ind_q;
    // Slot 25 falls off on the next step, so the lane empties if slots 0..24 are clear.
    assign drained     = (arr_q[ARRAY_W-ARROW_W-1:0] == '0);

endmodule

// File: rtl/arrow_scroll_scheduler.sv
// Two-player arrow scroll scheduler: run/drain FSM and frame counter that
// paces one-slot scroll steps for both player lanes.
module arrow_scroll_scheduler
    import dance_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP       = 4,
    parameter int unsigned INDICATOR_HOLD_FRAMES = 30
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               vsync_pulse,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic [ARROW_W-1:0] p1_new_arrow,
    input  logic               p1_new_valid,
    output logic               p1_new_ready,
    input  logic [ARROW_W-1:0] p2_new_arrow,
    input  logic               p2_new_valid,
    output logic               p2_new_ready,
    input  logic [GRADE_W-1:0] p1_hit_grade,
    input  logic               p1_hit_valid,
    input  logic [GRADE_W-1:0] p2_hit_grade,
    input  logic               p2_hit_valid,
    output logic [ARRAY_W-1:0] p1_arrow_array,
    output logic [ARRAY_W-1:0] p2_arrow_array,
    output logic [GRADE_W-1:0] p1_indicator,
    output logic [GRADE_W-1:0] p2_indicator,
    output logic               step_tick,
    output logic               busy
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

    state_e     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       step_tick_q, step_tick_d;
    logic       step;
    logic       run;
    logic       p1_drained, p2_drained;

    assign run       = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign step_tick = step_tick_q;

    always_comb begin
        step = !clear && (state_q != ST_IDLE) && vsync_pulse && (frame_cnt_q == LAST_FRAME);

        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start && !stop) state_d = ST_RUN;
                ST_RUN:   if (stop) state_d = ST_DRAIN;
                ST_DRAIN: if (step && p1_drained && p2_drained) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        frame_cnt_d = frame_cnt_q;
        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            frame_cnt_d = '0;
        end else if (vsync_pulse) begin
            frame_cnt_d = (frame_cnt_q == LAST_FRAME) ? 8'd0 : frame_cnt_q + 8'd1;
        end

        // Registered so the pulse appears together with the shifted arrays.
        step_tick_d = step;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            step_tick_q <= step_tick_d;
        end
    end

    player_lane_state #(.HOLD_FRAMES(INDICATOR_HOLD_FRAMES)) u_p1 (
        .clock       (clock),
        .resetn      (resetn),
        .run         (run),
        .clear       (clear),
        .step        (step),
        .vsync_pulse (vsync_pulse),
        .new_arrow   (p1_new_arrow),
        .new_valid   (p1_new_valid),
        .new_ready   (p1_new_ready),
        .hit_grade   (p1_hit_grade),
        .hit_valid   (p1_hit_valid),
        .arrow_array (p1_arrow_array),
        .indicator   (p1_indicator),
        .drained     (p1_drained)
    );

    player_lane_state #(.HOLD_FRAMES(INDICATOR_HOLD_FRAMES)) u_p2 (
        .clock       (clock),
        .resetn      (resetn),
        .run         (run),
        .clear       (clear),
        .step        (step),
        .vsync_pulse (vsync_pulse),
        .new_arrow   (p2_new_arrow),
        .new_valid   (p2_new_valid),
        .new_ready   (p2_new_ready),
        .hit_grade   (p2_hit_grade),
        .hit_valid   (p2_hit_valid),
        .arrow_array (p2_arrow_array),
        .indicator   (p2_indicator),
        .drained     (p2_drained)
    );

endmodule

// File: tb/tb_arrow_scroll_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_arrow_scroll_scheduler;

    localparam int FPS   = 4;
    localparam int HOLD  = 3;
    localparam int SLOTS = 26;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        vsync_pulse = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [2:0]  p1_new_arrow = '0, p2_new_arrow = '0;
    logic        p1_new_valid = 1'b0, p2_new_valid = 1'b0;
    logic        p1_new_ready, p2_new_ready;
    logic [1:0]  p1_hit_grade = '0, p2_hit_grade = '0;
    logic        p1_hit_valid = 1'b0, p2_hit_valid = 1'b0;
    logic [77:0] p1_arrow_array, p2_arrow_array;
    logic [1:0]  p1_indicator, p2_indicator;
    logic        step_tick, busy;

    always #5 clock = ~clock;

    arrow_scroll_scheduler #(.FRAMES_PER_STEP(FPS), .INDICATOR_HOLD_FRAMES(HOLD)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .vsync_pulse    (vsync_pulse),
        .start          (start),
        .stop           (stop),
        .clear          (clear),
        .p1_new_arrow   (p1_new_arrow),
        .p1_new_valid   (p1_new_valid),
        .p1_new_ready   (p1_new_ready),
        .p2_new_arrow   (p2_new_arrow),
        .p2_new_valid   (p2_new_valid),
        .p2_new_ready   (p2_new_ready),
        .p1_hit_grade   (p1_hit_grade),
        .p1_hit_valid   (p1_hit_valid),
        .p2_hit_grade   (p2_hit_grade),
        .p2_hit_valid   (p2_hit_valid),
        .p1_arrow_array (p1_arrow_array),
        .p2_arrow_array (p2_arrow_array),
        .p1_indicator   (p1_indicator),
        .p2_indicator   (p2_indicator),
        .step_tick      (step_tick),
        .busy           (busy)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0 idle, 1 run, 2 drain; slots as a plain array per player.
    int         m_state;
    int         m_cnt;
    logic [2:0] m_slot [2][SLOTS];
    bit         m_pv [2];
    logic [2:0] m_pa [2];
    bit         m_sv [2];
    logic [1:0] m_sg [2];
    int         m_hold [2];
    logic [1:0] m_ind [2];
    bit         m_tick;
    bit         m_cap [2];

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_tick  = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < SLOTS; k++) m_slot[p][k] = 3'b000;
            m_pv[p] = 0; m_pa[p] = 3'b000; m_sv[p] = 0; m_sg[p] = 2'b00;
            m_hold[p] = 0; m_ind[p] = 2'b00; m_cap[p] = 0;
        end
    endtask

    function automatic bit model_ready(input int p);
        return (m_state == 1) && !clear && !m_pv[p];
    endfunction

    function automatic logic [77:0] pack(input int p);
        logic [77:0] v;
        v = '0;
        for (int k = 0; k < SLOTS; k++) v[3*k +: 3] = m_slot[p][k];
        return v;
    endfunction

    function automatic bit model_all_empty();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < SLOTS; k++)
                if (m_slot[p][k] != 3'b000) return 0;
        return 1;
    endfunction

    task automatic model_clock();
        bit         stp;
        int         nstate;
        bit         nv [2];
        logic [2:0] na [2];
        bit         hv [2];
        logic [1:0] hg [2];
        nv[0] = p1_new_valid; na[0] = p1_new_arrow; hv[0] = p1_hit_valid; hg[0] = p1_hit_grade;
        nv[1] = p2_new_valid; na[1] = p2_new_arrow; hv[1] = p2_hit_valid; hg[1] = p2_hit_grade;
        for (int p = 0; p < 2; p++) m_cap[p] = nv[p] && model_ready(p);

        stp = !clear && m_state != 0 && vsync_pulse && m_cnt == FPS - 1;
        nstate = m_state;
        if (clear) nstate = 0;
        else if (m_state == 0 && start && !stop) nstate = 1;
        else if (m_state == 1 && stop) nstate = 2;

        for (int p = 0; p < 2; p++) begin
            if (clear) begin
                for (int k = 0; k < SLOTS; k++) m_slot[p][k] = 3'b000;
            end else if (stp) begin
                for (int k = SLOTS - 1; k > 0; k--) m_slot[p][k] = m_slot[p][k-1];
                m_slot[p][0] = (m_state == 1 && m_pv[p]) ? m_pa[p] : 3'b000;
            end
        end
        if (!clear && m_state == 2 && stp && model_all_empty()) nstate = 0;

        for (int p = 0; p < 2; p++) begin
            if (clear || m_state != 1) m_pv[p] = 0;
            else if (m_cap[p]) begin m_pv[p] = 1; m_pa[p] = na[p]; end
            else if (stp) m_pv[p] = 0;

            if (clear) begin
                m_sv[p] = 0; m_hold[p] = 0; m_ind[p] = 2'b00;
            end else begin
                if (vsync_pulse) begin
                    if (m_sv[p]) begin
                        m_ind[p] = m_sg[p]; m_hold[p] = HOLD; m_sv[p] = 0;
                    end else if (m_hold[p] > 0) begin
                        m_hold[p]--;
                        if (m_hold[p] == 0) m_ind[p] = 2'b00;
                    end
                end
                if (hv[p]) begin m_sv[p] = 1; m_sg[p] = hg[p]; end
            end
        end

        if (m_state == 0 || nstate == 0) m_cnt = 0;
        else if (vsync_pulse) m_cnt = (m_cnt + 1) % FPS;
        m_tick  = stp;
        m_state = nstate;
    endtask

    task automatic compare_all();
        check("step_tick", 78'(step_tick), 78'(m_tick));
        check("busy", 78'(busy), 78'(m_state != 0));
        check("p1_new_ready", 78'(p1_new_ready), 78'(model_ready(0)));
        check("p2_new_ready", 78'(p2_new_ready), 78'(model_ready(1)));
        check("p1_arrow_array", p1_arrow_array, pack(0));
        check("p2_arrow_array", p2_arrow_array, pack(1));
        check("p1_indicator", 78'(p1_indicator), 78'(m_ind[0]));
        check("p2_indicator", 78'(p2_indicator), 78'(m_ind[1]));
    endtask

    // Called at a falling edge with this cycle's inputs already applied.
    task automatic cycle();
        #1 compare_all();
        @(posedge clock);
        if (resetn) model_clock();
        @(negedge clock);
        vsync_pulse = 0; start = 0; stop = 0; clear = 0;
        p1_hit_valid = 0; p2_hit_valid = 0;
        if (m_cap[0]) p1_new_valid = 0;
        if (m_cap[1]) p2_new_valid = 0;
    endtask

    task automatic step_once();
        bit got;
        got = 0;
        for (int n = 0; n < FPS + 1 && !got; n++) begin
            vsync_pulse = 1;
            cycle();
            got = m_tick;
            if (!got) cycle();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got no step expected a step at %0t", $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_step_tick"}, 78'(step_tick), 78'(0));
        check({tag, "_busy"}, 78'(busy), 78'(0));
        check({tag, "_p1_ready"}, 78'(p1_new_ready), 78'(0));
        check({tag, "_p2_ready"}, 78'(p2_new_ready), 78'(0));
        check({tag, "_p1_array"}, p1_arrow_array, 78'(0));
        check({tag, "_p2_array"}, p2_arrow_array, 78'(0));
        check({tag, "_p1_ind"}, 78'(p1_indicator), 78'(0));
        check({tag, "_p2_ind"}, 78'(p2_indicator), 78'(0));
    endtask

    task automatic apply_reset();
        vsync_pulse = 0; start = 0; stop = 0; clear = 0;
        p1_new_valid = 0; p2_new_valid = 0; p1_hit_valid = 0; p2_hit_valid = 0;
        #2 resetn = 0;
        model_reset();
        #1 check_reset_values("midreset");
        @(negedge clock);
        #1 compare_all();
        @(negedge clock);
        resetn = 1;
    endtask

    logic [2:0] codes [6];

    initial begin
        codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
        codes[3] = 3'b011; codes[4] = 3'b100; codes[5] = 3'b110;
        model_reset();
        @(negedge clock);
        #1 check_reset_values("reset");
        @(negedge clock);
        resetn = 1;

        // First step: up arrow inserted before the first step.
        start = 1;
        cycle();
        p1_new_valid = 1; p1_new_arrow = 3'b001;
        cycle();
        for (int i = 0; i < 4; i++) begin
            vsync_pulse = 1;
            cycle();
            check("first_step_tick", 78'(step_tick), 78'(i == 3));
            if (i < 3) cycle();
        end
        check("first_p1_slot0", 78'(p1_arrow_array[2:0]), 78'(3'b001));
        check("first_p2_array", p2_arrow_array, 78'(0));

        // Capture on a step cycle waits for the following step.
        cycle();
        for (int i = 0; i < 3; i++) begin vsync_pulse = 1; cycle(); cycle(); end
        vsync_pulse = 1; p1_new_valid = 1; p1_new_arrow = 3'b010;
        cycle();
        check("cap_step_tick", 78'(step_tick), 78'(1));
        check("cap_slot0_empty", 78'(p1_arrow_array[2:0]), 78'(3'b000));
        check("cap_slot1_up", 78'(p1_arrow_array[5:3]), 78'(3'b001));
        check("cap_ready_full", 78'(p1_new_ready), 78'(0));
        cycle();
        step_once();
        check("cap_slot0_left", 78'(p1_arrow_array[2:0]), 78'(3'b010));

        // Full traversal of the playfield.
        repeat (25) step_once();
        check("travel_slot25", 78'(p1_arrow_array[77:75]), 78'(3'b010));
        step_once();
        check("travel_gone", p1_arrow_array, 78'(0));

        // Indicator hold with HOLD=3.
        cycle();
        p2_hit_valid = 1; p2_hit_grade = 2'b11;
        cycle();
        check("ind_not_yet", 78'(p2_indicator), 78'(0));
        vsync_pulse = 1;
        cycle();
        check("ind_shown", 78'(p2_indicator), 78'(2'b11));
        for (int i = 1; i <= 3; i++) begin
            cycle();
            vsync_pulse = 1;
            cycle();
            check("ind_hold", 78'(p2_indicator), 78'((i == 3) ? 2'b00 : 2'b11));
        end

        // Drain with arrows in slots 3 and 20.
        p1_new_valid = 1; p1_new_arrow = 3'b100;
        cycle();
        step_once();
        repeat (16) step_once();
        p1_new_valid = 1; p1_new_arrow = 3'b110;
        cycle();
        step_once();
        repeat (3) step_once();
        check("drain_slot20", 78'(p1_arrow_array[62:60]), 78'(3'b100));
        check("drain_slot3", 78'(p1_arrow_array[11:9]), 78'(3'b110));
        stop = 1;
        cycle();
        p1_new_valid = 1; p1_new_arrow = 3'b001;
        #1 check("drain_busy_entry", 78'(busy), 78'(1));
        check("drain_ready", 78'(p1_new_ready), 78'(0));
        for (int i = 1; i <= 23; i++) begin
            step_once();
            if (i == 6) check("drain_slot20_flushed", 78'(p1_arrow_array[77:60]), 78'(0));
            check("drain_busy", 78'(busy), 78'(i < 23));
        end
        check("drain_empty", p1_arrow_array, 78'(0));
        p1_new_valid = 0;
        cycle();

        // Clear beats stop; then an asynchronous reset mid-frame.
        start = 1;
        cycle();
        p2_new_valid = 1; p2_new_arrow = 3'b011;
        cycle();
        step_once();
        check("clr_p2_slot0", 78'(p2_arrow_array[2:0]), 78'(3'b011));
        p1_hit_valid = 1; p1_hit_grade = 2'b10;
        cycle();
        vsync_pulse = 1;
        cycle();
        check("clr_p1_ind", 78'(p1_indicator), 78'(2'b10));
        clear = 1; stop = 1;
        cycle();
        check("clr_busy", 78'(busy), 78'(0));
        check("clr_p1_array", p1_arrow_array, 78'(0));
        check("clr_p2_array", p2_arrow_array, 78'(0));
        check("clr_p1_ind", 78'(p1_indicator), 78'(0));
        check("clr_p2_ind", 78'(p2_indicator), 78'(0));
        start = 1;
        cycle();
        p1_new_valid = 1; p1_new_arrow = 3'b001;
        cycle();
        step_once();
        p2_hit_valid = 1; p2_hit_grade = 2'b01;
        vsync_pulse = 1;
        cycle();
        vsync_pulse = 1;
        cycle();
        apply_reset();
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            vsync_pulse = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 119) == 0);
            clear = ($urandom_range(0, 299) == 0);
            if (!p1_new_valid && $urandom_range(0, 3) == 0) begin
                p1_new_valid = 1; p1_new_arrow = codes[$urandom_range(0, 5)];
            end
            if (!p2_new_valid && $urandom_range(0, 3) == 0) begin
                p2_new_valid = 1; p2_new_arrow = codes[$urandom_range(0, 5)];
            end
            p1_hit_valid = ($urandom_range(0, 19) == 0);
            p1_hit_grade = 2'($urandom_range(0, 3));
            p2_hit_valid = ($urandom_range(0, 19) == 0);
            p2_hit_grade = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
